// File: rtl/mod_counter_pkg.sv
// Shared encodings and default sizes for the programmable-modulo timer/event counter.
// Optional feature macro used by the counter: MOD_COUNTER_STICKY_EN.
package mod_counter_pkg;

    localparam int   WIDTH_DEF      = 8;
    localparam int   PRESCALE_W_DEF = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;

endpackage

// File: rtl/mod_counter_prescaler.sv
// Prescaler for mod_counter: emits one tick every (prescale+1) enabled cycles.
// A live prescale below the current phase is treated as an immediate match.
module mod_counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] PCNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] pcnt_q;
    logic [PRESCALE_W-1:0] pcnt_d;

    // Next prescaler phase and tick decode
    always_comb begin
        pcnt_d = pcnt_q;
        tick   = 1'b0;
        if (en && (pcnt_q >= prescale)) begin
            tick = 1'b1;
        end else begin
            tick = 1'b0;
        end
        if (clr) begin
            pcnt_d = '0;
        end else if (en) begin
            if (tick) begin
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PCNT_ONE;
            end
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Prescaler phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Programmable-modulo up/down counter with prescaler, parallel load, wrap/saturate
// mode and terminal-count/wrap flags. Optional sticky overflow via MOD_COUNTER_STICKY_EN.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  sat_mode,
    input  logic [WIDTH-1:0]      mod_max,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
`ifdef MOD_COUNTER_STICKY_EN
    input  logic                  ovf_clr,
    output logic                  ovf_sticky,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             tick;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

    mod_counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    // Load/step datapath; bounds are compared before any arithmetic so 2^WIDTH never wraps
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            if (load_val > mod_max) begin
                count_d = mod_max;
            end else begin
                count_d = load_val;
            end
        end else if (tick) begin
            if (up == DIR_UP) begin
                if (count_q < mod_max) begin
                    count_d = count_q + CNT_ONE;
                end else if (sat_mode == MODE_SAT) begin
                    count_d = mod_max;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q > mod_max) begin
                    count_d = mod_max;
                end else if (count_q != '0) begin
                    count_d = count_q - CNT_ONE;
                end else if (sat_mode == MODE_SAT) begin
                    count_d = '0;
                end else begin
                    count_d = mod_max;
                    wrap_d  = 1'b1;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count and wrap-pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef MOD_COUNTER_STICKY_EN
    logic ovf_sticky_q;
    logic ovf_sticky_d;

    // Sticky overflow: a new wrap outranks a simultaneous clear
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (wrap_d) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end else begin
            ovf_sticky_d = ovf_sticky_q;
        end
    end

    // Sticky overflow register
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
`endif

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = (up == DIR_UP) ? (count_q >= mod_max) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH=4, PRESCALE_W=4).
// Sticky-overflow checks are included when MOD_COUNTER_STICKY_EN is defined.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       sat_mode;
    logic [3:0] mod_max;
    logic [3:0] prescale;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tc;
    logic       wrap;
`ifdef MOD_COUNTER_STICKY_EN
    logic       ovf_clr;
    logic       ovf_sticky;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mod_counter #(
        .WIDTH      (4),
        .PRESCALE_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .sat_mode   (sat_mode),
        .mod_max    (mod_max),
        .prescale   (prescale),
        .load       (load),
        .load_val   (load_val),
`ifdef MOD_COUNTER_STICKY_EN
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky),
`endif
        .count      (count),
        .tc         (tc),
        .wrap       (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        rst = 1'b1; en = 1'b0; up = 1'b1; sat_mode = 1'b0; mod_max = 4'd9;
        prescale = 4'd0; load = 1'b0; load_val = 4'd0;
`ifdef MOD_COUNTER_STICKY_EN
        ovf_clr = 1'b0;
`endif
        // 1: reset and idle hold
        repeat (3) cyc();
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_tc_up", {31'd0, tc}, 32'd0);
        up = 1'b0;
        #1;
        chk("rst_tc_down", {31'd0, tc}, 32'd1);
`ifdef MOD_COUNTER_STICKY_EN
        chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
`endif
        rst = 1'b0; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("idle_hold", {28'd0, count}, 32'd0);
        end

        // 2: wrap mode up count 0..9 then 0
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("up_count", {28'd0, count}, i % 10);
            chk("up_wrap", {31'd0, wrap}, (i == 10) ? 32'd1 : 32'd0);
            chk("up_tc", {31'd0, tc}, (i == 9) ? 32'd1 : 32'd0);
        end
        en = 1'b0;
        cyc();
        chk("en0_hold", {28'd0, count}, 32'd0);
        chk("en0_wrap_clr", {31'd0, wrap}, 32'd0);

        // 3: prescale=2 with an enable gap mid-period
        prescale = 4'd2; mod_max = 4'd15; en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("pre_count", {28'd0, count}, (i >= 3) ? 32'd1 : 32'd0);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pre_gap_hold", {28'd0, count}, 32'd1);
        end
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            exp_cnt = (i == 5) ? 3 : ((i >= 2) ? 2 : 1);
            chk("pre_resume", {28'd0, count}, exp_cnt);
        end

        // 4: saturate down from a load, then clamped load
        prescale = 4'd0; mod_max = 4'd9; sat_mode = 1'b1; up = 1'b0;
        load = 1'b1; load_val = 4'd2;
        cyc();
        chk("load_2", {28'd0, count}, 32'd2);
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("sat_down", {28'd0, count}, (i == 1) ? 32'd1 : 32'd0);
            chk("sat_down_wrap", {31'd0, wrap}, 32'd0);
        end
        chk("tc_down_zero", {31'd0, tc}, 32'd1);
        load = 1'b1; load_val = 4'd12;
        cyc();
        chk("load_clamp", {28'd0, count}, 32'd9);
        load = 1'b0; mod_max = 4'd5;
        cyc();
        chk("down_reenter", {28'd0, count}, 32'd5);
        chk("down_reenter_wrap", {31'd0, wrap}, 32'd0);
        load = 1'b1; load_val = 4'd0;
        cyc();
        load = 1'b0; sat_mode = 1'b0;
        cyc();
        chk("down_wrap_count", {28'd0, count}, 32'd5);
        chk("down_wrap_pulse", {31'd0, wrap}, 32'd1);
        mod_max = 4'd0; up = 1'b1;
        cyc();
        chk("mod0_count_a", {28'd0, count}, 32'd0);
        chk("mod0_wrap_a", {31'd0, wrap}, 32'd1);
        cyc();
        chk("mod0_count_b", {28'd0, count}, 32'd0);
        chk("mod0_wrap_b", {31'd0, wrap}, 32'd1);

        // 5: load beats step; reset beats load
        mod_max = 4'd9; load = 1'b1; load_val = 4'd5;
        cyc();
        chk("load_5", {28'd0, count}, 32'd5);
        load_val = 4'd3;
        cyc();
        chk("load_over_tick", {28'd0, count}, 32'd3);
        chk("load_no_wrap", {31'd0, wrap}, 32'd0);
        rst = 1'b1; load_val = 4'd7;
        cyc();
        chk("rst_over_load", {28'd0, count}, 32'd0);
        rst = 1'b0; load = 1'b0; en = 1'b0;

`ifdef MOD_COUNTER_STICKY_EN
        // 6: sticky overflow set/clear priority
        mod_max = 4'd0; up = 1'b1; sat_mode = 1'b0; en = 1'b1;
        cyc();
        chk("sticky_set", {31'd0, ovf_sticky}, 32'd1);
        en = 1'b0;
        cyc();
        chk("sticky_persist", {31'd0, ovf_sticky}, 32'd1);
        en = 1'b1; ovf_clr = 1'b1;
        cyc();
        chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
        en = 1'b0;
        cyc();
        chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);
        ovf_clr = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
